// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Memory stage of the 5-stage RV32I pipeline, between the E/M register and
//   writeback. Issues loads/stores to data memory over a req/ready handshake,
//   steers store bytes onto lanes, extracts and extends load data, stalls
//   upstream while an access is outstanding, and owns the M/W register.
//
//   State table:
//     state  | meaning
//     IDLE   | no access outstanding; an aligned memop here is latched and issued
//     REQ    | mem_req asserted with request outputs held; waiting for mem_ready
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_M .. PCPlus4_M instruction fields presented by the E/M register
//   stall_M             hold E/M and all upstream stages
//   mem_req/we/addr/wdata/wstrb, mem_ready, mem_rdata  data memory handshake
//   valid_W, regWrite_W, Rd_W, result_W, misaligned_W   M/W register outputs

module mem_stage_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_M,
  input  logic             regWrite_M,
  input  logic [1:0]       resultSrc_M,
  input  logic             memWrite_M,
  input  logic [2:0]       funct3_M,
  input  logic [4:0]       Rd_M,
  input  logic [WIDTH-1:0] ALUResult_M,
  input  logic [WIDTH-1:0] writeData_M,
  input  logic [WIDTH-1:0] PCPlus4_M,
  output logic             stall_M,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             valid_W,
  output logic             regWrite_W,
  output logic [4:0]       Rd_W,
  output logic [WIDTH-1:0] result_W,
  output logic             misaligned_W
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       funct3_q, funct3_d;

  logic             valid_W_q, valid_W_d;
  logic             regWrite_W_q, regWrite_W_d;
  logic [4:0]       Rd_W_q, Rd_W_d;
  logic [WIDTH-1:0] result_W_q, result_W_d;
  logic             misaligned_W_q, misaligned_W_d;

  logic             memop, mis, is_half, is_word, done, wb_load;
  logic [1:0]       off;
  logic [WIDTH-1:0] st_wdata, ld_data, res_sel;
  logic [3:0]       st_wstrb;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign off     = ALUResult_M[1:0];
  assign is_half = (funct3_M[1:0] == 2'b01);
  // funct3[1] set covers word plus the reserved 011/110/111 encodings
  assign is_word = funct3_M[1];
  assign memop   = valid_M && (memWrite_M || resultSrc_M == 2'b01);
  assign mis     = (is_half && off[0]) || (is_word && off != 2'b00);
  assign done    = (state_q == S_REQ) && mem_ready;
  assign stall_M = memop && !mis && !done;

  // Store lane steering
  always_comb begin
    st_wdata = writeData_M;
    st_wstrb = 4'b1111;
    case (funct3_M[1:0])
      2'b00: begin
        st_wdata = {4{writeData_M[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{writeData_M[15:0]}};
        st_wstrb = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  // Load lane extraction uses the offset/funct3 captured with the request
  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Request FSM
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    case (state_q)
      S_IDLE: begin
        if (memop && !mis) begin
          state_d     = S_REQ;
          mem_addr_d  = {ALUResult_M[WIDTH-1:2], 2'b00};
          mem_we_d    = memWrite_M;
          mem_wdata_d = st_wdata;
          mem_wstrb_d = memWrite_M ? st_wstrb : 4'b0000;
          off_d       = off;
          funct3_d    = funct3_M;
        end
      end
      S_REQ: begin
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // M/W register: load on retire, bubble otherwise
  always_comb begin
    case (resultSrc_M)
      2'b00:   res_sel = ALUResult_M;
      2'b01:   res_sel = ld_data;
      2'b10:   res_sel = PCPlus4_M;
      default: res_sel = '0;
    endcase
    wb_load        = valid_M && !stall_M;
    valid_W_d      = wb_load;
    regWrite_W_d   = wb_load && regWrite_M && !(mis && memop);
    misaligned_W_d = wb_load && mis && memop;
    Rd_W_d         = wb_load ? Rd_M : Rd_W_q;
    result_W_d     = wb_load ? res_sel : result_W_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= 4'b0000;
      off_q          <= 2'b00;
      funct3_q       <= 3'b000;
      valid_W_q      <= 1'b0;
      regWrite_W_q   <= 1'b0;
      Rd_W_q         <= 5'd0;
      result_W_q     <= '0;
      misaligned_W_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrb_q    <= mem_wstrb_d;
      off_q          <= off_d;
      funct3_q       <= funct3_d;
      valid_W_q      <= valid_W_d;
      regWrite_W_q   <= regWrite_W_d;
      Rd_W_q         <= Rd_W_d;
      result_W_q     <= result_W_d;
      misaligned_W_q <= misaligned_W_d;
    end
  end

  assign mem_req      = (state_q == S_REQ);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign valid_W      = valid_W_q;
  assign regWrite_W   = regWrite_W_q;
  assign Rd_W         = Rd_W_q;
  assign result_W     = result_W_q;
  assign misaligned_W = misaligned_W_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed scenarios followed by random
// instruction streams, with a scoreboard of expected writebacks and memory
// requests and a memory responder with variable latency.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_M, regWrite_M, memWrite_M;
  logic [1:0]  resultSrc_M;
  logic [2:0]  funct3_M;
  logic [4:0]  Rd_M;
  logic [31:0] ALUResult_M, writeData_M, PCPlus4_M;
  logic        stall_M, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        valid_W, regWrite_W, misaligned_W;
  logic [4:0]  Rd_W;
  logic [31:0] result_W;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_M(valid_M), .regWrite_M(regWrite_M),
    .resultSrc_M(resultSrc_M), .memWrite_M(memWrite_M), .funct3_M(funct3_M),
    .Rd_M(Rd_M), .ALUResult_M(ALUResult_M), .writeData_M(writeData_M),
    .PCPlus4_M(PCPlus4_M), .stall_M(stall_M), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .valid_W(valid_W),
    .regWrite_W(regWrite_W), .Rd_W(Rd_W), .result_W(result_W),
    .misaligned_W(misaligned_W)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        check_result;
    logic        mis;
  } wb_t;

  req_t        req_q[$];
  wb_t         exp_q[$];
  int          lat_q[$];
  logic [31:0] mem_model[1024];
  logic [31:0] ref_mem[1024];
  int          n_chk = 0;
  int          n_pass = 0;
  int          forced_lat = -1;
  bit          hold_ready = 0;
  bit          stall_mem = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Memory responder: acts on the memory side of the handshake
  initial begin
    int   lat;
    int   lat_init;
    int   idx;
    bit   in_req;
    bit   prev_hs;
    req_t r;
    mem_ready = 1'b0;
    mem_rdata = '0;
    in_req    = 0;
    prev_hs   = 0;
    lat       = 0;
    lat_init  = 0;
    forever begin
      @(negedge clk);
      if (prev_hs) chk("req_gap_after_access", 32'(mem_req), 32'd0);
      prev_hs = 0;
      if (rst) begin
        in_req    = 0;
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (req_q.size() == 0) begin
          chk("spurious_mem_req", 32'(mem_req), 32'd0);
          mem_ready = 1'b0;
        end else begin
          r = req_q[0];
          chk("req_addr", mem_addr, r.addr);
          chk("req_we", 32'(mem_we), 32'(r.we));
          if (r.we) begin
            chk("req_wdata", mem_wdata, r.wdata);
            chk("req_wstrb", 32'(mem_wstrb), 32'(r.wstrb));
          end
          if (!in_req) begin
            in_req   = 1;
            lat      = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
            lat_init = lat;
          end
          if (!stall_mem && lat == 0) begin
            idx       = int'(mem_addr[11:2]);
            mem_ready = 1'b1;
            mem_rdata = mem_model[idx];
            if (mem_we)
              for (int j = 0; j < 4; j++)
                if (mem_wstrb[j]) mem_model[idx][8*j +: 8] = mem_wdata[8*j +: 8];
            lat_q.push_back(1 + lat_init);
            void'(req_q.pop_front());
            in_req  = 0;
            prev_hs = 1;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (lat > 0) lat--;
          end
        end
      end else begin
        mem_ready = hold_ready ? 1'b1 : 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Writeback monitor
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (valid_W === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_W", 32'(valid_W), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("regWrite_W", 32'(regWrite_W), 32'(e.regwrite));
          chk("Rd_W", 32'(Rd_W), 32'(e.rd));
          chk("misaligned_W", 32'(misaligned_W), 32'(e.mis));
          if (e.check_result) chk("result_W", result_W, e.result);
        end
      end
    end
  end

  initial begin
    #400000;
    n_chk++;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  // Issues one instruction (called just after a rising edge) and holds it while stalled
  task automatic issue(input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                       input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc);
    int          sz, off, idx, stalls, cycles, exp_st;
    bit          memop, mis;
    logic [31:0] w, v, res;
    req_t        r;
    wb_t         e;
    valid_M = 1'b1; resultSrc_M = rs; memWrite_M = mw; funct3_M = f3;
    regWrite_M = rw; Rd_M = rd; ALUResult_M = alu; writeData_M = wd; PCPlus4_M = pc;

    memop = (mw == 1'b1) || (rs == 2'b01);
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(alu[1:0]);
    mis   = memop && ((off % sz) != 0);
    idx   = int'(alu[11:2]);

    res = 32'h0;
    if (rs == 2'b00) res = alu;
    else if (rs == 2'b10) res = pc;
    else if (rs == 2'b01 && !mis) begin
      w = ref_mem[idx];
      if (sz == 1) begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      res = v;
    end

    if (memop && !mis) begin
      r.addr  = alu & ~32'h3;
      r.we    = mw;
      r.wdata = 32'h0;
      r.wstrb = 4'h0;
      if (mw) begin
        w = ref_mem[idx];
        for (int b = 0; b < sz; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
        ref_mem[idx] = w;
        for (int j = 0; j < 4; j++) begin
          r.wdata[8*j +: 8] = wd[8*(j % sz) +: 8];
          r.wstrb[j] = (j >= off) && (j < off + sz);
        end
      end
      req_q.push_back(r);
    end

    e.regwrite     = rw && !mis;
    e.rd           = rd;
    e.result       = res;
    e.check_result = !(mis && rs == 2'b01);
    e.mis          = mis;
    exp_q.push_back(e);

    stalls = 0;
    cycles = 0;
    forever begin
      @(negedge clk);
      #2;
      cycles++;
      if (stall_M !== 1'b1) break;
      stalls++;
      if (cycles > 40) begin
        n_chk++;
        $display("FAIL stall_timeout: stall_M=%0b after %0d cycles, required 0", stall_M, cycles);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "stall timeout");
      end
    end
    exp_st = 0;
    if (memop && !mis) exp_st = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
    chk("stall_cycles", 32'(stalls), 32'(exp_st));
    @(posedge clk);
    #1;
    valid_M = 1'b0;
  endtask

  task automatic bubble(input int n);
    valid_M = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_model[i] = $urandom;
      ref_mem[i]   = mem_model[i];
    end
    mem_model[32'h40] = 32'h80FF_0011;
    ref_mem[32'h40]   = 32'h80FF_0011;

    rst = 1'b1; valid_M = 1'b0; regWrite_M = 1'b0; resultSrc_M = 2'b00; memWrite_M = 1'b0;
    funct3_M = 3'b000; Rd_M = 5'd0; ALUResult_M = '0; writeData_M = '0; PCPlus4_M = '0;

    // Reset state
    @(negedge clk);
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_valid_W", 32'(valid_W), 32'd0);
    chk("rst_regWrite_W", 32'(regWrite_W), 32'd0);
    chk("rst_Rd_W", 32'(Rd_W), 32'd0);
    chk("rst_result_W", result_W, 32'd0);
    chk("rst_misaligned_W", 32'(misaligned_W), 32'd0);
    chk("rst_stall_M", 32'(stall_M), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset while a load is waiting in REQ
    stall_mem = 1;
    valid_M = 1'b1; resultSrc_M = 2'b01; memWrite_M = 1'b0; funct3_M = 3'b010;
    regWrite_M = 1'b1; Rd_M = 5'd7; ALUResult_M = 32'h40;
    req_q.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    repeat (3) @(negedge clk);
    #2;
    chk("midrst_req_before", 32'(mem_req), 32'd1);
    chk("midrst_stall_before", 32'(stall_M), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; valid_M = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_valid_W", 32'(valid_W), 32'd0);
    chk("midrst_stall_M", 32'(stall_M), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    req_q.delete();
    stall_mem = 0;
    @(posedge clk);
    #1;

    // ALU pass-through
    issue(2'b00, 1'b0, 3'b000, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h8);
    // Signed / unsigned byte loads with 3 stall cycles
    forced_lat = 2;
    issue(2'b01, 1'b0, 3'b000, 1'b1, 5'd9, 32'h103, 32'h0, 32'h0);
    issue(2'b01, 1'b0, 3'b100, 1'b1, 5'd10, 32'h103, 32'h0, 32'h0);
    forced_lat = -1;
    bubble(1);
    // Halfword store
    issue(2'b00, 1'b1, 3'b001, 1'b0, 5'd3, 32'h202, 32'hAAAA_BEEF, 32'h0);
    // Misaligned word load
    issue(2'b01, 1'b0, 3'b010, 1'b1, 5'd4, 32'h6, 32'h0, 32'h0);
    // Back-to-back SW then LW, ready held high
    hold_ready = 1; forced_lat = 0;
    bubble(1);
    issue(2'b00, 1'b1, 3'b010, 1'b0, 5'd0, 32'h300, 32'hCAFE_F00D, 32'h0);
    issue(2'b01, 1'b0, 3'b010, 1'b1, 5'd12, 32'h300, 32'h0, 32'h0);
    hold_ready = 0; forced_lat = -1;

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [1:0]  rs;
      logic [2:0]  f3;
      logic [31:0] a;
      hold_ready = (n >= 100 && n < 200);
      if ($urandom_range(0, 3) == 0) bubble(int'($urandom_range(1, 2)));
      kind = int'($urandom_range(0, 2));
      a    = 32'($urandom_range(0, 4095));
      case (kind)
        0: begin
          rs = 2'($urandom_range(0, 2));
          if (rs == 2'b01) rs = 2'b11;
          issue(rs, 1'b0, 3'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
        end
        1: begin
          f3 = 3'($urandom);
          issue(2'b01, 1'b0, f3, 1'($urandom), 5'($urandom), a, $urandom, $urandom);
        end
        default: begin
          f3 = 3'($urandom_range(0, 2));
          issue(2'b00, 1'b1, f3, 1'($urandom), 5'($urandom), a, $urandom, $urandom);
        end
      endcase
    end
    hold_ready = 0;

    bubble(3);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
